// File: rtl/game_sequencer_if.sv
// Game-flow bus between the sequencer and the playfield/ball update logic.
// Latency: none, plain wires; the sequencer registers its own outputs.
// Backpressure: none, strobes are fire-and-forget; `hit` is the only return path.
//
// Signals:
//   start      level, begin/restart a game          (playfield -> sequencer)
//   hit        collision flag                       (playfield -> sequencer)
//   pause      level, freeze the run (GAME_PAUSE_EN only)
//   tick       one-cycle game-update strobe         (sequencer -> playfield)
//   spawn      one-cycle obstacle strobe, only with tick
//   obst_type  obstacle shape 0/1/2 while spawn=1, else 0
//   score      spawns survived, saturating at 255
//   period     current tick period in clk cycles
//   state      0 IDLE, 1 RUN, 2 DEAD, 3 PAUSED
interface game_sequencer_if;
  logic       start;
  logic       hit;
`ifdef GAME_PAUSE_EN
  logic       pause;
`endif
  logic       tick;
  logic       spawn;
  logic [1:0] obst_type;
  logic [7:0] score;
  logic [7:0] period;
  logic [1:0] state;

  // master = the sequencer, slave = the playfield logic
  modport master (
    input  start,
    input  hit,
`ifdef GAME_PAUSE_EN
    input  pause,
`endif
    output tick,
    output spawn,
    output obst_type,
    output score,
    output period,
    output state
  );

  modport slave (
    output start,
    output hit,
`ifdef GAME_PAUSE_EN
    output pause,
`endif
    input  tick,
    input  spawn,
    input  obst_type,
    input  score,
    input  period,
    input  state
  );
endinterface

// File: rtl/game_sequencer.sv
// Game-flow controller: game FSM, game-tick divider, obstacle spawn scheduler
// with LFSR-chosen shape, difficulty ramp (gap first, then period) and score.
// Latency: start/hit/pause act on the next edge; no backpressure, strobes are
// one cycle and never stall.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous, active-low reset
//   bus        game_sequencer_if.master (start, hit, [pause] in;
//              tick, spawn, obst_type, score, period, state out)
// Optional feature: define GAME_PAUSE_EN to add the `pause` input and the
// PAUSED state (code 3). Without it state 3 is never produced.
//
// tick/spawn/obst_type are decoded from registered state (div, gapcnt, LFSR)
// and gated by `hit`, so a collision in a tick cycle cancels that update.
module game_sequencer #(
  parameter int unsigned BASE_PERIOD = 50,
  parameter int unsigned MIN_PERIOD  = 16,
  parameter int unsigned PERIOD_STEP = 2,
  parameter int unsigned BASE_GAP    = 50,
  parameter int unsigned MIN_GAP     = 15,
  parameter int unsigned GAP_STEP    = 2
) (
  input  logic              clk,
  input  logic              rst,
  game_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DEAD   = 2'd2,
    ST_PAUSED = 2'd3
  } state_e;

  localparam logic [7:0] BASE_PERIOD_L = 8'(BASE_PERIOD);
  localparam logic [7:0] MIN_PERIOD_L  = 8'(MIN_PERIOD);
  localparam logic [7:0] PERIOD_STEP_L = 8'(PERIOD_STEP);
  localparam logic [7:0] BASE_GAP_L    = 8'(BASE_GAP);
  localparam logic [7:0] GAP_STEP_L    = 8'(GAP_STEP);
  localparam logic [7:0] LFSR_SEED     = 8'hA5;

  // "x - step >= floor" rewritten as "x >= floor + step" in 9 bits, so the
  // test itself can never wrap.
  localparam logic [8:0] GAP_THRESH    = 9'(MIN_GAP + GAP_STEP);
  localparam logic [8:0] PERIOD_THRESH = 9'(MIN_PERIOD + PERIOD_STEP);

  state_e     state_q,  state_d;
  logic [7:0] div_q,    div_d;
  logic [7:0] gapcnt_q, gapcnt_d;
  logic [7:0] gap_q,    gap_d;
  logic [7:0] period_q, period_d;
  logic [7:0] score_q,  score_d;
  logic [7:0] lfsr_q,   lfsr_d;

  logic       tick_w;
  logic       spawn_w;
  logic       load_run;

  function automatic logic [1:0] mod3(input logic [7:0] v);
    logic [7:0] r;
    r = v % 8'd3;
    return r[1:0];
  endfunction

  // Tick fires on the last count of the interval unless a collision lands
  // in the same cycle; spawn rides on the tick that closes the gap.
  assign tick_w   = (state_q == ST_RUN) && (div_q == period_q - 8'd1) && !bus.hit;
  assign spawn_w  = tick_w && (gapcnt_q == gap_q - 8'd1);
  assign load_run = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DEAD));

  // ---------------------------------------------------------------- FSM: state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DEAD: begin
        if (bus.start) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Collision takes priority over pausing.
        if (bus.hit) begin
          state_d = ST_DEAD;
        end
`ifdef GAME_PAUSE_EN
        else if (bus.pause) begin
          state_d = ST_PAUSED;
        end
`endif
      end
      ST_PAUSED: begin
`ifdef GAME_PAUSE_EN
        if (!bus.pause) state_d = ST_RUN;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- FSM: outputs
  always_comb begin
    bus.tick      = tick_w;
    bus.spawn     = spawn_w;
    bus.obst_type = spawn_w ? mod3(lfsr_q) : 2'd0;
    bus.score     = score_q;
    bus.period    = period_q;
    bus.state     = state_q;
  end

  // ---------------------------------------------------------------- datapath next values
  always_comb begin
    div_d    = div_q;
    gapcnt_d = gapcnt_q;
    gap_d    = gap_q;
    period_d = period_q;
    score_d  = score_q;
    // x^8+x^6+x^5+x^4+1, shifting towards the MSB; free-runs in every state
    lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    if (load_run) begin
      div_d    = 8'd0;
      gapcnt_d = 8'd0;
      period_d = BASE_PERIOD_L;
      gap_d    = BASE_GAP_L;
      score_d  = 8'd0;
    end else if (state_q == ST_RUN && !bus.hit) begin
      if (tick_w) begin
        div_d = 8'd0;
        if (spawn_w) begin
          gapcnt_d = 8'd0;
          if (score_q != 8'hFF) score_d = score_q + 8'd1;
          // Shrink the gap first; once it is at its floor, speed up the tick.
          if ({1'b0, gap_q} >= GAP_THRESH) begin
            gap_d = gap_q - GAP_STEP_L;
          end else if ({1'b0, period_q} >= PERIOD_THRESH) begin
            period_d = period_q - PERIOD_STEP_L;
          end else begin
            period_d = MIN_PERIOD_L;
          end
        end else begin
          gapcnt_d = gapcnt_q + 8'd1;
        end
      end else begin
        div_d = div_q + 8'd1;
      end
    end
    // A hit in RUN freezes everything on its way to DEAD; PAUSED, IDLE and
    // DEAD hold the counters as well.
  end

  // ---------------------------------------------------------------- datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q    <= 8'd0;
      gapcnt_q <= 8'd0;
      gap_q    <= BASE_GAP_L;
      period_q <= BASE_PERIOD_L;
      score_q  <= 8'd0;
      lfsr_q   <= LFSR_SEED;
    end else begin
      div_q    <= div_d;
      gapcnt_q <= gapcnt_d;
      gap_q    <= gap_d;
      period_q <= period_d;
      score_q  <= score_d;
      lfsr_q   <= lfsr_d;
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with a cycle-level reference model.
// The model tracks absolute tick times and remaining ticks to the next spawn.
module tb_game_sequencer;
  localparam int BP   = 4;
  localparam int MINP = 2;
  localparam int PS   = 1;
  localparam int BG   = 3;
  localparam int MING = 2;
  localparam int GS   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  game_sequencer_if bus();

  game_sequencer #(
    .BASE_PERIOD(BP), .MIN_PERIOD(MINP), .PERIOD_STEP(PS),
    .BASE_GAP(BG), .MIN_GAP(MING), .GAP_STEP(GS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic pause_in;
`ifdef GAME_PAUSE_EN
  assign pause_in = bus.pause;
`else
  assign pause_in = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // ------------------------------------------------------------ reference model
  typedef struct packed {
    bit         valid;
    int         state;
    int         next_tick;   // absolute cycle index of the next tick
    int         left;        // ticks remaining until (and including) the spawn tick
    int         period;
    int         gap;
    int         score;
    logic [7:0] lfsr;
  } model_t;

  model_t m = '0;
  int     cyc = 0;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic model_t model_step(input model_t c, input logic r, input logic st,
                                        input logic h, input logic p, input int now);
    model_t n;
    n = c;
    if (!r) begin
      n.valid = 1'b1; n.state = 0; n.period = BP; n.gap = BG; n.score = 0;
      n.lfsr = 8'hA5; n.next_tick = 0; n.left = 0;
      return n;
    end
    n.lfsr = lfsr_next(c.lfsr);
    case (c.state)
      0, 2: if (st) begin
        n.state = 1; n.next_tick = now + BP; n.left = BG;
        n.period = BP; n.gap = BG; n.score = 0;
      end
      1: begin
        if (h) n.state = 2;
        else begin
          if (now == c.next_tick) begin
            if (c.left == 1) begin
              n.score = (c.score < 255) ? c.score + 1 : 255;
              if (c.gap - GS >= MING) n.gap = c.gap - GS;
              else n.period = (c.period - PS > MINP) ? c.period - PS : MINP;
              n.left = n.gap;
            end else begin
              n.left = c.left - 1;
            end
            n.next_tick = now + n.period;
          end
          if (p) n.state = 3;
        end
      end
      3: begin
        n.next_tick = c.next_tick + 1;  // every frozen cycle pushes the tick back
        if (!p) n.state = 1;
      end
      default: n.state = 0;
    endcase
    return n;
  endfunction

  always @(posedge clk) begin
    m   <= model_step(m, rst, bus.start, bus.hit, pause_in, cyc);
    cyc <= cyc + 1;
  end

  // ------------------------------------------------------------ per-cycle compare
  bit e_tick, e_spawn;
  int e_obst;
  always @(negedge clk) begin
    if (m.valid) begin
      e_tick  = (m.state == 1) && (cyc == m.next_tick) && !bus.hit;
      e_spawn = e_tick && (m.left == 1);
      e_obst  = e_spawn ? int'(m.lfsr) % 3 : 0;
      check("cyc_tick",   int'(bus.tick),      int'(e_tick));
      check("cyc_spawn",  int'(bus.spawn),     int'(e_spawn));
      check("cyc_obst",   int'(bus.obst_type), e_obst);
      check("cyc_state",  int'(bus.state),     m.state);
      check("cyc_score",  int'(bus.score),     m.score);
      check("cyc_period", int'(bus.period),    m.period);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ directed stimulus
  int tick_k [9] = '{4, 8, 12, 16, 20, 23, 26, 28, 30};
  int spawn_k[4] = '{12, 20, 26, 30};

  task automatic wait_tick(input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.tick) found = 1'b1;
    end
    check(name, int'(found), 1);
  endtask

  initial begin
    bit exp_t, exp_s;
    int sp;
    int sc;
    rst = 1'b0; bus.start = 1'b0; bus.hit = 1'b0;
`ifdef GAME_PAUSE_EN
    bus.pause = 1'b0;
`endif
    // Reset held for 3 edges
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state",  int'(bus.state), 0);
    check("rst_tick",   int'(bus.tick), 0);
    check("rst_spawn",  int'(bus.spawn), 0);
    check("rst_score",  int'(bus.score), 0);
    check("rst_obst",   int'(bus.obst_type), 0);
    check("rst_period", int'(bus.period), BP);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("model_lfsr_seed", int'(m.lfsr), 8'hA5);
    check("model_lfsr_step", int'(lfsr_next(8'hA5)), 8'h4A);

    // Cadence and ramp: ticks/spawns counted in RUN cycles
    repeat (2) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      @(negedge clk);
      exp_t = 1'b0; exp_s = 1'b0;
      foreach (tick_k[j])  if (tick_k[j] == k)  exp_t = 1'b1;
      foreach (spawn_k[j]) if (spawn_k[j] == k) exp_s = 1'b1;
      check($sformatf("ramp_tick_k%0d", k),  int'(bus.tick),  int'(exp_t));
      check($sformatf("ramp_spawn_k%0d", k), int'(bus.spawn), int'(exp_s));
      if (exp_s) check($sformatf("ramp_obst_range_k%0d", k), int'(bus.obst_type < 2'd3), 1);
      if (k == 1)  check("run_state",        int'(bus.state), 1);
      if (k == 13) check("score_first",      int'(bus.score), 1);
      if (k == 13) check("period_after_1",   int'(bus.period), 4);
      if (k == 21) check("score_second",     int'(bus.score), 2);
      if (k == 21) check("period_step_3",    int'(bus.period), 3);
      if (k == 27) check("period_step_2",    int'(bus.period), 2);
      if (k == 31) check("period_floor",     int'(bus.period), 2);
      if (k == 31) check("score_fourth",     int'(bus.score), 4);
    end

    // Saturation: 300 more spawns
    sp = 0;
    for (int i = 0; i < 3000 && sp < 300; i++) begin
      @(negedge clk);
      if (bus.spawn) sp++;
    end
    check("spawns_seen", sp, 300);
    @(negedge clk);
    check("score_saturated", int'(bus.score), 255);

    // Hit in a tick cycle (period is 2 here)
    wait_tick("tick_before_hit");
    @(posedge clk);
    @(posedge clk); #1 bus.hit = 1'b1;
    @(negedge clk);
    check("hit_tick_suppressed",  int'(bus.tick), 0);
    check("hit_spawn_suppressed", int'(bus.spawn), 0);
    @(posedge clk); #1 bus.hit = 1'b0;
    @(negedge clk);
    check("dead_state", int'(bus.state), 2);
    sc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.tick) sc++;
    end
    check("dead_no_ticks",    sc, 0);
    check("dead_score_kept",  int'(bus.score), 255);
    check("dead_period_kept", int'(bus.period), 2);

    // Restart from DEAD
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    @(negedge clk);
    check("restart_state",  int'(bus.state), 1);
    check("restart_score",  int'(bus.score), 0);
    check("restart_period", int'(bus.period), BP);

    // Reset mid-run, between two ticks
    wait_tick("tick_before_rst");
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_state",  int'(bus.state), 0);
    check("midrst_period", int'(bus.period), BP);
    check("midrst_tick",   int'(bus.tick), 0);
    @(posedge clk); #1 rst = 1'b1;

`ifdef GAME_PAUSE_EN
    // Pause 20 cycles mid-interval; hit is ignored while paused
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_tick("tick_before_pause");
    begin
      int c;
      bit seen;
      c = 0; seen = 1'b0;
      while (!seen && c < 100) begin
        @(posedge clk); #1;
        c++;
        bus.pause = (c >= 1 && c <= 20);
        bus.hit   = (c >= 5 && c <= 8);
        @(negedge clk);
        if (c == 10) check("paused_state", int'(bus.state), 3);
        if (bus.tick) seen = 1'b1;
      end
      check("pause_resume_tick_delay", c, 24);
      check("pause_after_state", int'(bus.state), 1);
    end
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
